// File: rtl/conv_row_feeder_if.sv
// Pixel-in / row-out bus of conv_row_feeder.
// The feeder owns the row bus and the ready line, so it takes the master view.
// The line fetch and conv_PE side takes the slave view.
interface conv_row_feeder_if #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned LANES = 32,
    parameter int unsigned CNTW  = 7
) ();
    logic                   flush;
    logic [WIDTH-1:0]       pix_in;
    logic                   pix_valid;
    logic                   pix_ready;
    logic [LANES*WIDTH-1:0] row_data;
    logic                   init;
    logic                   row_valid;
    logic                   frame_done;
    logic [CNTW-1:0]        pix_count;

    modport master (
        input  flush, pix_in, pix_valid,
        output pix_ready, row_data, init, row_valid, frame_done, pix_count
    );

    modport slave (
        output flush, pix_in, pix_valid,
        input  pix_ready, row_data, init, row_valid, frame_done, pix_count
    );
endinterface

// File: rtl/conv_row_feeder.sv
// conv_row_feeder: gathers a serial pixel stream into a ROWS x LANES buffer.
// It then plays the rows out to conv_PE one per cycle with init high.
// Each frame ends with a single all-zero gap cycle that pulses frame_done.
module conv_row_feeder #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned LANES = 32,
    parameter int unsigned ROWS  = 3,
    parameter int unsigned CNTW  = $clog2(LANES*ROWS+1)
) (
    input  logic              clk,
    input  logic              rst_n,
    conv_row_feeder_if.master bus
);
    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned RW = $clog2(ROWS);
    localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_EMIT = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                 state;
    logic [LW-1:0]          lane_cnt;
    logic [RW-1:0]          row_cnt;
    logic [RW-1:0]          emit_cnt;
    logic                   accept;
    logic [LANES*WIDTH-1:0] pix_buf [ROWS];

    // A pixel is taken only while filling; flush overrides a simultaneous accept.
    always_comb begin
        accept = bus.pix_valid && (state == S_FILL) && !bus.flush;
    end

    assign bus.pix_ready = (state == S_FILL);

    // Row-major buffer write. The buffer has no reset because its contents are don't-care until filled.
    always_ff @(posedge clk) begin
        if (accept) begin
            pix_buf[row_cnt][lane_cnt*WIDTH +: WIDTH] <= bus.pix_in;
        end
    end

    // Frame sequencer: FILL counts pixels in, EMIT plays the rows out, GAP idles for one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_FILL;
            lane_cnt       <= '0;
            row_cnt        <= '0;
            emit_cnt       <= '0;
            bus.pix_count  <= '0;
            bus.row_data   <= '0;
            bus.init       <= 1'b0;
            bus.row_valid  <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            unique case (state)
                S_FILL: begin
                    if (bus.flush) begin
                        lane_cnt      <= '0;
                        row_cnt       <= '0;
                        bus.pix_count <= '0;
                    end else if (accept) begin
                        bus.pix_count <= bus.pix_count + 1'b1;
                        if (lane_cnt == LANE_LAST) begin
                            lane_cnt <= '0;
                            if (row_cnt == ROW_LAST) begin
                                // Row 0 was completed on an earlier edge, so it can be read while the last row is written.
                                row_cnt       <= '0;
                                emit_cnt      <= '0;
                                state         <= S_EMIT;
                                bus.row_data  <= pix_buf[0];
                                bus.init      <= 1'b1;
                                bus.row_valid <= 1'b1;
                            end else begin
                                row_cnt <= row_cnt + 1'b1;
                            end
                        end else begin
                            lane_cnt <= lane_cnt + 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (emit_cnt == ROW_LAST) begin
                        state          <= S_GAP;
                        bus.row_data   <= '0;
                        bus.init       <= 1'b0;
                        bus.row_valid  <= 1'b0;
                        bus.frame_done <= 1'b1;
                    end else begin
                        emit_cnt     <= emit_cnt + 1'b1;
                        bus.row_data <= pix_buf[emit_cnt + 1'b1];
                    end
                end
                S_GAP: begin
                    state          <= S_FILL;
                    bus.frame_done <= 1'b0;
                    lane_cnt       <= '0;
                    row_cnt        <= '0;
                    emit_cnt       <= '0;
                    bus.pix_count  <= '0;
                end
                default: begin
                    state <= S_FILL;
                end
            endcase
        end
    end
endmodule
